// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and constants for the gantry move sequencer and its command
// queue.
//   state_t     : sequencer FSM states
//   move_cmd_t  : one queued move {axis, dir, steps}
//   AXIS_X/Y    : axis encodings used in move_cmd_t.axis
//   CMD_W       : flattened width of move_cmd_t, used on FIFO ports
//   sat_inc     : 32-bit saturating increment used by the shared counter
// ---------------------------------------------------------------------------
package motor_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    typedef struct packed {
        logic        axis;
        logic        dir;
        logic [31:0] steps;
    } move_cmd_t;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    localparam int CMD_W = $bits(move_cmd_t);

    // Counter that sticks at all-ones instead of wrapping back to zero, so a
    // long wait can never look like a freshly entered state.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO holding flattened move_cmd_t words.
// Ports:
//   i_Clk     in   clock
//   i_rst_n   in   asynchronous active-low reset, empties the queue
//   i_flush   in   synchronous flush, empties the queue on the next edge
//   i_push    in   write i_data (accepted when not full, or when full and
//                  a pop happens in the same cycle)
//   i_data    in   word to write
//   i_pop     in   drop the head word (ignored when empty)
//   o_data    out  current head word, valid while !o_empty
//   o_full    out  queue holds DEPTH words
//   o_empty   out  queue holds no words
// ---------------------------------------------------------------------------
module cmd_fifo
    import motor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [CMD_W-1:0] i_data,
    input  logic             i_pop,
    output logic [CMD_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [CMD_W-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells a full queue (same index, different lap)
    // from an empty one (same index, same lap).
    assign o_empty = (wr_ptr_reg == rd_ptr_reg);
    assign o_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // The head has to be visible in the same cycle the sequencer decides to
    // pop it, so the read side is a plain array lookup.
    assign o_data = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge i_Clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/motor_move_sequencer.sv
// ---------------------------------------------------------------------------
// motor_move_sequencer
// Queues move commands for the X/Y stepper axes and runs them strictly one at
// a time: launch pulse to one driver, wait for its done pulse, settle, retire.
// A watchdog on the done wait raises a sticky fault and flushes the queue.
// Ports:
//   i_Clk        in   system clock
//   i_rst_n      in   asynchronous active-low reset
//   i_cmd_valid  in   command offered
//   o_cmd_ready  out  queue not full and no fault
//   i_cmd_axis   in   0 = X, 1 = Y
//   i_cmd_dir    in   direction forwarded to the driver
//   i_cmd_steps  in   step count (0 = settle only, no launch)
//   o_mtr_en     out  one-hot one-cycle launch pulse, bit n to driver n
//   o_mtr_dir    out  shared direction bus, held from pop to next pop
//   o_mtr_steps  out  shared step-count bus, held from pop to next pop
//   i_mtr_done   in   one-cycle done pulse from each driver
//   o_move_done  out  one-cycle pulse per retired command
//   o_idle       out  queue empty and FSM idle
//   o_fault      out  sticky watchdog fault, cleared only by reset
// ---------------------------------------------------------------------------
module motor_move_sequencer
    import motor_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        i_Clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_axis,
    input  logic        i_cmd_dir,
    input  logic [31:0] i_cmd_steps,
    output logic [1:0]  o_mtr_en,
    output logic        o_mtr_dir,
    output logic [31:0] o_mtr_steps,
    input  logic [1:0]  i_mtr_done,
    output logic        o_move_done,
    output logic        o_idle,
    output logic        o_fault
);

    // Last counter value of each timed state. A settle of 0 behaves as 1.
    localparam logic [31:0] SETTLE_LAST  =
        (SETTLE_CYCLES <= 1) ? 32'd0 : 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES <= 1) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [31:0]      cnt_reg;
    logic [31:0]      cnt_next;

    logic             cur_axis_reg;
    logic             cur_axis_next;
    logic             cur_dir_reg;
    logic             cur_dir_next;
    logic [31:0]      cur_steps_reg;
    logic [31:0]      cur_steps_next;

    logic [1:0]       mtr_en_reg;
    logic [1:0]       mtr_en_next;
    logic             move_done_reg;
    logic             move_done_next;
    logic             fault_reg;
    logic             fault_next;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    move_cmd_t        head;
    logic             done_sel;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign o_cmd_ready = !fifo_full && !fault_reg;
    assign fifo_push   = i_cmd_valid && o_cmd_ready;
    assign fifo_wdata  = {i_cmd_axis, i_cmd_dir, i_cmd_steps};
    assign head        = move_cmd_t'(fifo_rdata);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_Clk   (i_Clk),
        .i_rst_n (i_rst_n),
        .i_flush (fifo_flush),
        .i_push  (fifo_push),
        .i_data  (fifo_wdata),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Only the driver of the axis currently moving may retire the move.
    assign done_sel = i_mtr_done[cur_axis_reg];

    // ------------------------------------------------------------------
    // State register (FSM state plus the shared watchdog/settle counter)
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty && !fault_reg) begin
                    state_next = (head.steps == 32'd0) ? S_SETTLE : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the very last watchdog cycle still wins.
                if (done_sel) begin
                    state_next = S_SETTLE;
                end else if (cnt_reg >= TIMEOUT_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt_reg >= SETTLE_LAST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic. Registered outputs are computed from the
    // next state so that they are valid during the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        cur_axis_next  = cur_axis_reg;
        cur_dir_next   = cur_dir_reg;
        cur_steps_next = cur_steps_reg;
        fault_next     = fault_reg;

        cnt_next = sat_inc(cnt_reg);
        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        if ((state_reg == S_IDLE) && (state_next != S_IDLE)) begin
            fifo_pop       = 1'b1;
            cur_axis_next  = head.axis;
            cur_dir_next   = head.dir;
            cur_steps_next = head.steps;
        end

        // The only way out of S_WAIT back to S_IDLE is the watchdog.
        if ((state_reg == S_WAIT) && (state_next == S_IDLE)) begin
            fault_next = 1'b1;
            fifo_flush = 1'b1;
        end

        move_done_next = (state_next == S_SETTLE) && (cnt_next >= SETTLE_LAST);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mtr_en
        assign mtr_en_next[gi] = (state_next == S_LAUNCH) &&
                                 (int'(cur_axis_next) == gi);
    end

    // ------------------------------------------------------------------
    // Output and current-command registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_axis_reg  <= AXIS_X;
            cur_dir_reg   <= 1'b0;
            cur_steps_reg <= '0;
            mtr_en_reg    <= '0;
            move_done_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            cur_axis_reg  <= cur_axis_next;
            cur_dir_reg   <= cur_dir_next;
            cur_steps_reg <= cur_steps_next;
            mtr_en_reg    <= mtr_en_next;
            move_done_reg <= move_done_next;
            fault_reg     <= fault_next;
        end
    end

    assign o_mtr_en    = mtr_en_reg;
    assign o_mtr_dir   = cur_dir_reg;
    assign o_mtr_steps = cur_steps_reg;
    assign o_move_done = move_done_reg;
    assign o_fault     = fault_reg;
    assign o_idle      = fifo_empty && (state_reg == S_IDLE);

endmodule

// File: doc/motor_move_sequencer.md
# motor_move_sequencer

Queues move commands for the two stepper axes of the klotski gantry and issues them one at a time to the per-axis stepper drivers (enable/direction/step-count in, done pulse back). It enforces strict serialisation: only one axis moves at any time. A settle delay is inserted after every move, and a watchdog detects a driver that never reports done. It sits between the puzzle-solver move generator and the two stepper-driver instances.

## Interface
Parameters:
- FIFO_DEPTH, 4: command queue depth; power of two, at least 2.
- SETTLE_CYCLES, 50000: idle cycles after each move. A value of 0 is treated as 1.
- TIMEOUT_CYCLES, 50_000_000: maximum cycles to wait for a driver done.

Ports:
- i_Clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  queue not full and not faulted.
- i_cmd_axis  in  1  0 = X, 1 = Y.
- i_cmd_dir  in  1  direction forwarded to the driver.
- i_cmd_steps  in  32  step count.
- o_mtr_en  out  2  one-hot, one-cycle launch pulse; bit n goes to driver n.
- o_mtr_dir  out  1  shared direction bus to both drivers.
- o_mtr_steps  out  32  shared step-count bus to both drivers.
- i_mtr_done  in  2  one-cycle done pulse from each driver.
- o_move_done  out  1  one-cycle pulse per retired command.
- o_idle  out  1  queue empty and FSM in S_IDLE.
- o_fault  out  1  sticky watchdog fault.

## Operation
- **Enqueue:** a command is enqueued on any cycle with i_cmd_valid && o_cmd_ready. It is ignored otherwise.
- **Ready:** o_cmd_ready = !full && !o_fault.
- **FSM states:**
  - S_IDLE: if the queue is non-empty, pop the head into cur_axis/cur_dir/cur_steps. If cur_steps == 0, go to S_SETTLE; otherwise go to S_LAUNCH.
  - S_LAUNCH: o_mtr_en[cur_axis] = 1 for exactly this one cycle, then go to S_WAIT.
  - S_WAIT: wait for i_mtr_done[cur_axis], then go to S_SETTLE. A done pulse on the other axis is ignored. If the watchdog reaches TIMEOUT_CYCLES-1, set o_fault, flush the queue and go to S_IDLE; no o_move_done is issued.
  - S_SETTLE: count max(SETTLE_CYCLES,1) cycles. o_move_done pulses on the last of them, then go to S_IDLE.
- **Fault:** while o_fault is set, S_IDLE does not pop and new commands are refused. Only reset clears o_fault.
- **Output buses:** o_mtr_dir and o_mtr_steps are registered from cur_*. They are updated on the pop and held until the next pop, so they are stable on the launch cycle and throughout the move.
- **Counters:**
  - A single 32-bit counter serves both the watchdog and the settle count. It is cleared on every state entry and saturates (no wrap).
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, to distinguish full from empty.
- **Simultaneous push and pop:** allowed when the queue is full (the pop frees a slot the same cycle) and when it is empty (the pushed entry is not popped until the next cycle; no bypass).

## Timing
- **Reset values:** o_mtr_en = 0, o_mtr_dir = 0, o_mtr_steps = 0, o_move_done = 0, o_fault = 0, o_idle = 1, o_cmd_ready = 1. Queue is empty and the FSM is in S_IDLE.
- **Registered outputs:** all outputs are registered except o_cmd_ready and o_idle, which are decoded from registers.
- **Launch latency:** a command pushed at edge T into an empty, idle sequencer is popped at edge T+1. o_mtr_en is high during cycle T+2.
- **Settle after done:** a done pulse sampled at edge D enters S_SETTLE at D+1. o_move_done is high during cycle D+max(SETTLE_CYCLES,1), and the FSM is in S_IDLE at the next edge.
- **Back-to-back commands:** a queued next command is popped on the first S_IDLE cycle. The gap from o_move_done to the next o_mtr_en is 2 cycles.
- **Reset mid-move:** the FSM aborts immediately and all outputs return to their reset values. The driver must be reset by the same i_rst_n.

## Structure
- **Shared package motor_pkg:**
  - the state_t enum (S_IDLE, S_LAUNCH, S_WAIT, S_SETTLE);
  - the move_cmd_t packed struct {axis, dir, steps[31:0]};
  - the AXIS_X and AXIS_Y constants.
- **Sub-module cmd_fifo:** parameterised synchronous FIFO of move_cmd_t, with push/pop/full/empty and an asynchronous flush-by-reset input plus a synchronous flush input.

## Test plan
- **Single move:** SETTLE_CYCLES = 4; push {X, 1, 10} into the idle block.
  - o_mtr_en = 2'b01 for 1 cycle, two cycles after the push, with o_mtr_steps = 10 and o_mtr_dir = 1.
  - A model driver returns done; o_move_done pulses 4 cycles later and o_idle returns to 1.
- **Queue full:** push 5 commands while the first is running.
  - o_cmd_ready drops after the 4th is queued.
  - All 4 accepted moves execute in order, each followed by an o_move_done pulse; axes never overlap.
- **Zero-step command:** push {Y, 0, 0}.
  - o_mtr_en is never asserted; o_move_done pulses after the settle period.
- **Wrong-axis done:** during an X move, pulse i_mtr_done[1].
  - The FSM stays in S_WAIT; only i_mtr_done[0] retires the move.
- **Timeout:** TIMEOUT_CYCLES = 20, with 3 commands queued and no done pulses.
  - o_fault rises at cycle 20 of S_WAIT, the queue flushes and o_cmd_ready = 0.
  - No further o_mtr_en pulses occur until reset.
- **Reset mid-WAIT:** assert i_rst_n low during S_WAIT.
  - All outputs return to their reset values immediately; a new push afterwards launches normally.
